// File: rtl/instr_fetch_stage.sv
// Fetch stage: assembles 16/32-bit instruction bundles, resolves RJMP/JMP locally
// and steers the program counter on stall, flush and taken jumps.
module instr_fetch_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instruction,
   input  logic [13:0] program_counter,
   input  logic        stall,
   input  logic        flush,
   input  logic [13:0] ex_target,
   output logic        PC_overwrite,
   output logic [13:0] PC_new,
   output logic        ir_valid,
   output logic [15:0] ir_word0,
   output logic [15:0] ir_word1,
   output logic        ir_two_word,
   output logic [13:0] ir_pc
);

   typedef enum logic [0:0] {FETCH = 1'b0, WORD2 = 1'b1} state_t;

   function automatic logic is_two_word(input logic [15:0] w);
      return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
   endfunction

   function automatic logic is_rjmp(input logic [15:0] w);
      return (w[15:12] == 4'hC);
   endfunction

   function automatic logic is_jmp(input logic [15:0] w);
      return ((w & 16'hFE0E) == 16'h940C);
   endfunction

   state_t      state_q, state_d;
   logic        ir_valid_q, ir_valid_d;
   logic [15:0] ir_word0_q, ir_word0_d;
   logic [15:0] ir_word1_q, ir_word1_d;
   logic        ir_two_word_q, ir_two_word_d;
   logic [13:0] ir_pc_q, ir_pc_d;
   logic [15:0] held_word_q, held_word_d;
   logic [13:0] held_pc_q, held_pc_d;

   logic [13:0] pc_plus1_s;
   logic [13:0] rjmp_target_s;

   assign pc_plus1_s    = program_counter + 14'd1;
   assign rjmp_target_s = pc_plus1_s + {{2{instruction[11]}}, instruction[11:0]};

   // PC steering, in priority order: reset, flush, stall, local jump resolution.
   always_comb begin
      PC_overwrite = 1'b0;
      PC_new       = pc_plus1_s;
      if (reset) begin
         PC_overwrite = 1'b0;
         PC_new       = pc_plus1_s;
      end else if (flush) begin
         PC_overwrite = 1'b1;
         PC_new       = ex_target;
      end else if (stall) begin
         PC_overwrite = 1'b1;
         PC_new       = program_counter;
      end else if ((state_q == FETCH) && is_rjmp(instruction)) begin
         PC_overwrite = 1'b1;
         PC_new       = rjmp_target_s;
      end else if ((state_q == WORD2) && is_jmp(held_word_q)) begin
         PC_overwrite = 1'b1;
         PC_new       = instruction[13:0];
      end else begin
         PC_overwrite = 1'b0;
         PC_new       = pc_plus1_s;
      end
   end

   // Next-state and bundle register computation.
   always_comb begin
      state_d       = state_q;
      ir_valid_d    = ir_valid_q;
      ir_word0_d    = ir_word0_q;
      ir_word1_d    = ir_word1_q;
      ir_two_word_d = ir_two_word_q;
      ir_pc_d       = ir_pc_q;
      held_word_d   = held_word_q;
      held_pc_d     = held_pc_q;
      if (flush) begin
         state_d     = FETCH;
         ir_valid_d  = 1'b0;
         held_word_d = 16'h0000;
         held_pc_d   = 14'h0000;
      end else if (stall) begin
         state_d = state_q;
      end else begin
         case (state_q)
            FETCH: begin
               if (is_rjmp(instruction)) begin
                  ir_valid_d = 1'b0;
               end else if (is_two_word(instruction)) begin
                  held_word_d = instruction;
                  held_pc_d   = program_counter;
                  ir_valid_d  = 1'b0;
                  state_d     = WORD2;
               end else begin
                  ir_valid_d    = 1'b1;
                  ir_word0_d    = instruction;
                  ir_word1_d    = 16'h0000;
                  ir_two_word_d = 1'b0;
                  ir_pc_d       = program_counter;
               end
            end
            WORD2: begin
               state_d = FETCH;
               if (is_jmp(held_word_q)) begin
                  ir_valid_d = 1'b0;
               end else begin
                  ir_valid_d    = 1'b1;
                  ir_word0_d    = held_word_q;
                  ir_word1_d    = instruction;
                  ir_two_word_d = 1'b1;
                  ir_pc_d       = held_pc_q;
               end
            end
            default: begin
               state_d    = FETCH;
               ir_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and bundle registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= FETCH;
         ir_valid_q    <= 1'b0;
         ir_word0_q    <= 16'h0000;
         ir_word1_q    <= 16'h0000;
         ir_two_word_q <= 1'b0;
         ir_pc_q       <= 14'h0000;
         held_word_q   <= 16'h0000;
         held_pc_q     <= 14'h0000;
      end else begin
         state_q       <= state_d;
         ir_valid_q    <= ir_valid_d;
         ir_word0_q    <= ir_word0_d;
         ir_word1_q    <= ir_word1_d;
         ir_two_word_q <= ir_two_word_d;
         ir_pc_q       <= ir_pc_d;
         held_word_q   <= held_word_d;
         held_pc_q     <= held_pc_d;
      end
   end

   assign ir_valid    = ir_valid_q;
   assign ir_word0    = ir_word0_q;
   assign ir_word1    = ir_word1_q;
   assign ir_two_word = ir_two_word_q;
   assign ir_pc       = ir_pc_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed testbench for instr_fetch_stage with hand-computed expectations.
module tb_instr_fetch_stage;

   logic        clk;
   logic        reset;
   logic [15:0] instruction;
   logic [13:0] program_counter;
   logic        stall;
   logic        flush;
   logic [13:0] ex_target;
   logic        PC_overwrite;
   logic [13:0] PC_new;
   logic        ir_valid;
   logic [15:0] ir_word0;
   logic [15:0] ir_word1;
   logic        ir_two_word;
   logic [13:0] ir_pc;

   int checks = 0;
   int errors = 0;

   instr_fetch_stage dut (
      .clk(clk), .reset(reset), .instruction(instruction),
      .program_counter(program_counter), .stall(stall), .flush(flush),
      .ex_target(ex_target), .PC_overwrite(PC_overwrite), .PC_new(PC_new),
      .ir_valid(ir_valid), .ir_word0(ir_word0), .ir_word1(ir_word1),
      .ir_two_word(ir_two_word), .ir_pc(ir_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply a fetch vector at the falling edge, settle before combinational checks.
   task automatic drive(input logic [15:0] w, input logic [13:0] pc,
                        input logic st, input logic fl, input logic [13:0] tgt);
      @(negedge clk);
      instruction = w; program_counter = pc; stall = st; flush = fl; ex_target = tgt;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(16'hC005, 14'd9, 1'b1, 1'b1, 14'd3);
      checks++; if (PC_overwrite !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %0b exp 0", PC_overwrite); end
      tick();
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b exp 0", ir_valid); end
      checks++; if (ir_word0 !== 16'h0000) begin errors++; $display("FAIL rst_w0: got %h exp 0000", ir_word0); end
      checks++; if (ir_word1 !== 16'h0000) begin errors++; $display("FAIL rst_w1: got %h exp 0000", ir_word1); end
      checks++; if (ir_two_word !== 1'b0) begin errors++; $display("FAIL rst_two: got %0b exp 0", ir_two_word); end
      checks++; if (ir_pc !== 14'h0000) begin errors++; $display("FAIL rst_pc: got %h exp 0000", ir_pc); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_nop();
      drive(16'h0000, 14'd5, 1'b0, 1'b0, 14'd0);
      checks++; if (PC_overwrite !== 1'b0) begin errors++; $display("FAIL nop_ovr: got %0b exp 0", PC_overwrite); end
      checks++; if (PC_new !== 14'd6) begin errors++; $display("FAIL nop_pcnew: got %0d exp 6", PC_new); end
      tick();
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL nop_valid: got %0b exp 1", ir_valid); end
      checks++; if (ir_word0 !== 16'h0000) begin errors++; $display("FAIL nop_w0: got %h exp 0000", ir_word0); end
      checks++; if (ir_pc !== 14'd5) begin errors++; $display("FAIL nop_pc: got %0d exp 5", ir_pc); end
      checks++; if (ir_two_word !== 1'b0) begin errors++; $display("FAIL nop_two: got %0b exp 0", ir_two_word); end
   endtask

   task automatic test_back_to_back();
      drive(16'h0A01, 14'd60, 1'b0, 1'b0, 14'd0);
      tick();
      checks++; if (ir_word0 !== 16'h0A01 || ir_pc !== 14'd60 || ir_valid !== 1'b1) begin
         errors++; $display("FAIL b2b_first: got w0=%h pc=%0d v=%0b exp w0=0a01 pc=60 v=1", ir_word0, ir_pc, ir_valid); end
      drive(16'h0B02, 14'h3FFF, 1'b0, 1'b0, 14'd0);
      checks++; if (PC_new !== 14'h0000) begin errors++; $display("FAIL b2b_wrap: got %h exp 0000", PC_new); end
      tick();
      checks++; if (ir_word0 !== 16'h0B02 || ir_pc !== 14'h3FFF || ir_valid !== 1'b1) begin
         errors++; $display("FAIL b2b_second: got w0=%h pc=%h v=%0b exp w0=0b02 pc=3fff v=1", ir_word0, ir_pc, ir_valid); end
   endtask

   task automatic test_lds();
      drive(16'h9000, 14'd10, 1'b0, 1'b0, 14'd0);
      checks++; if (PC_overwrite !== 1'b0 || PC_new !== 14'd11) begin
         errors++; $display("FAIL lds_w0_pc: got ovr=%0b new=%0d exp ovr=0 new=11", PC_overwrite, PC_new); end
      tick();
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL lds_bubble: got %0b exp 0", ir_valid); end
      drive(16'h0060, 14'd11, 1'b0, 1'b0, 14'd0);
      checks++; if (PC_overwrite !== 1'b0) begin errors++; $display("FAIL lds_w1_ovr: got %0b exp 0", PC_overwrite); end
      tick();
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL lds_valid: got %0b exp 1", ir_valid); end
      checks++; if (ir_word0 !== 16'h9000) begin errors++; $display("FAIL lds_w0: got %h exp 9000", ir_word0); end
      checks++; if (ir_word1 !== 16'h0060) begin errors++; $display("FAIL lds_w1: got %h exp 0060", ir_word1); end
      checks++; if (ir_pc !== 14'd10) begin errors++; $display("FAIL lds_pc: got %0d exp 10", ir_pc); end
      checks++; if (ir_two_word !== 1'b1) begin errors++; $display("FAIL lds_two: got %0b exp 1", ir_two_word); end
      drive(16'h0001, 14'd12, 1'b0, 1'b0, 14'd0);
      tick();
      checks++; if (ir_two_word !== 1'b0 || ir_word1 !== 16'h0000 || ir_word0 !== 16'h0001) begin
         errors++; $display("FAIL lds_after: got two=%0b w1=%h w0=%h exp two=0 w1=0000 w0=0001", ir_two_word, ir_word1, ir_word0); end
   endtask

   task automatic test_rjmp();
      drive(16'hCFFF, 14'd20, 1'b0, 1'b0, 14'd0);
      checks++; if (PC_overwrite !== 1'b1) begin errors++; $display("FAIL rjmp_ovr: got %0b exp 1", PC_overwrite); end
      checks++; if (PC_new !== 14'd20) begin errors++; $display("FAIL rjmp_back: got %0d exp 20", PC_new); end
      tick();
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rjmp_valid: got %0b exp 0", ir_valid); end
      drive(16'hC000, 14'h3FFF, 1'b0, 1'b0, 14'd0);
      checks++; if (PC_new !== 14'h0000) begin errors++; $display("FAIL rjmp_wrap: got %h exp 0000", PC_new); end
      tick();
      drive(16'hC7FF, 14'd0, 1'b0, 1'b0, 14'd0);
      checks++; if (PC_new !== 14'h0800) begin errors++; $display("FAIL rjmp_fwd: got %h exp 0800", PC_new); end
      tick();
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rjmp_fwd_valid: got %0b exp 0", ir_valid); end
   endtask

   task automatic test_jmp();
      drive(16'h940C, 14'd3, 1'b0, 1'b0, 14'd0);
      checks++; if (PC_overwrite !== 1'b0 || PC_new !== 14'd4) begin
         errors++; $display("FAIL jmp_first: got ovr=%0b new=%0d exp ovr=0 new=4", PC_overwrite, PC_new); end
      tick();
      drive(16'h0123, 14'd4, 1'b0, 1'b0, 14'd0);
      checks++; if (PC_overwrite !== 1'b1) begin errors++; $display("FAIL jmp_ovr: got %0b exp 1", PC_overwrite); end
      checks++; if (PC_new !== 14'h0123) begin errors++; $display("FAIL jmp_target: got %h exp 0123", PC_new); end
      tick();
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL jmp_valid: got %0b exp 0", ir_valid); end
      drive(16'h0002, 14'h0123, 1'b0, 1'b0, 14'd0);
      tick();
      checks++; if (ir_valid !== 1'b1 || ir_two_word !== 1'b0 || ir_pc !== 14'h0123) begin
         errors++; $display("FAIL jmp_return: got v=%0b two=%0b pc=%h exp v=1 two=0 pc=0123", ir_valid, ir_two_word, ir_pc); end
      // CALL is two-word but must be emitted, not resolved
      drive(16'h940E, 14'd70, 1'b0, 1'b0, 14'd0);
      tick();
      drive(16'hF123, 14'd71, 1'b0, 1'b0, 14'd0);
      checks++; if (PC_overwrite !== 1'b0) begin errors++; $display("FAIL call_ovr: got %0b exp 0", PC_overwrite); end
      tick();
      checks++; if (ir_valid !== 1'b1 || ir_word0 !== 16'h940E || ir_word1 !== 16'hF123 || ir_pc !== 14'd70) begin
         errors++; $display("FAIL call_emit: got v=%0b w0=%h w1=%h pc=%0d exp v=1 w0=940e w1=f123 pc=70", ir_valid, ir_word0, ir_word1, ir_pc); end
      drive(16'h940C, 14'd80, 1'b0, 1'b0, 14'd0);
      tick();
      drive(16'hF123, 14'd81, 1'b0, 1'b0, 14'd0);
      checks++; if (PC_new !== 14'h3123) begin errors++; $display("FAIL jmp_trunc: got %h exp 3123", PC_new); end
      tick();
   endtask

   task automatic test_stall_flush();
      drive(16'h1234, 14'd30, 1'b0, 1'b0, 14'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(16'h0000, 14'd31 + 14'(i), 1'b1, 1'b0, 14'd0);
         checks++; if (PC_overwrite !== 1'b1 || PC_new !== 14'd31 + 14'(i)) begin
            errors++; $display("FAIL stall_pc%0d: got ovr=%0b new=%0d exp ovr=1 new=%0d", i, PC_overwrite, PC_new, 31 + i); end
         tick();
         checks++; if (ir_valid !== 1'b1 || ir_word0 !== 16'h1234 || ir_pc !== 14'd30) begin
            errors++; $display("FAIL stall_hold%0d: got v=%0b w0=%h pc=%0d exp v=1 w0=1234 pc=30", i, ir_valid, ir_word0, ir_pc); end
      end
      drive(16'h9000, 14'd40, 1'b0, 1'b0, 14'd0);
      tick();
      drive(16'h0060, 14'd41, 1'b1, 1'b1, 14'd7);
      checks++; if (PC_overwrite !== 1'b1 || PC_new !== 14'd7) begin
         errors++; $display("FAIL flush_pc: got ovr=%0b new=%0d exp ovr=1 new=7", PC_overwrite, PC_new); end
      tick();
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b exp 0", ir_valid); end
      drive(16'h0001, 14'd7, 1'b0, 1'b0, 14'd0);
      checks++; if (PC_overwrite !== 1'b0 || PC_new !== 14'd8) begin
         errors++; $display("FAIL flush_next_pc: got ovr=%0b new=%0d exp ovr=0 new=8", PC_overwrite, PC_new); end
      tick();
      checks++; if (ir_valid !== 1'b1 || ir_word0 !== 16'h0001 || ir_two_word !== 1'b0 || ir_pc !== 14'd7) begin
         errors++; $display("FAIL flush_fetch: got v=%0b w0=%h two=%0b pc=%0d exp v=1 w0=0001 two=0 pc=7", ir_valid, ir_word0, ir_two_word, ir_pc); end
   endtask

   task automatic test_reset_word2();
      drive(16'h9000, 14'd50, 1'b0, 1'b0, 14'd0);
      tick();
      @(negedge clk);
      reset = 1'b1; instruction = 16'h0060; program_counter = 14'd51;
      #1;
      checks++; if (PC_overwrite !== 1'b0) begin errors++; $display("FAIL rw2_ovr: got %0b exp 0", PC_overwrite); end
      tick();
      checks++; if (ir_valid !== 1'b0 || ir_word0 !== 16'h0000 || ir_word1 !== 16'h0000 || ir_two_word !== 1'b0 || ir_pc !== 14'h0000) begin
         errors++; $display("FAIL rw2_clear: got v=%0b w0=%h w1=%h two=%0b pc=%h exp all 0", ir_valid, ir_word0, ir_word1, ir_two_word, ir_pc); end
      @(negedge clk);
      reset = 1'b0;
      drive(16'h0005, 14'd52, 1'b0, 1'b0, 14'd0);
      tick();
      checks++; if (ir_valid !== 1'b1 || ir_word0 !== 16'h0005 || ir_word1 !== 16'h0000 || ir_two_word !== 1'b0 || ir_pc !== 14'd52) begin
         errors++; $display("FAIL rw2_after: got v=%0b w0=%h w1=%h two=%0b pc=%0d exp v=1 w0=0005 w1=0000 two=0 pc=52", ir_valid, ir_word0, ir_word1, ir_two_word, ir_pc); end
   endtask

   initial begin
      reset = 1'b1; instruction = 16'h0000; program_counter = 14'd0;
      stall = 1'b0; flush = 1'b0; ex_target = 14'd0;
      test_reset();
      test_nop();
      test_back_to_back();
      test_lds();
      test_rjmp();
      test_jmp();
      test_stall_flush();
      test_reset_word2();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these data ports:
- instruction  in  16  word fetched at program_counter, valid in the same cycle
- program_counter  in  14  word address of instruction
- stall  in  1  execute stage cannot accept a new instruction
- flush  in  1  execute stage redirect request
- ex_target  in  14  redirect word address, qualified by flush
- PC_overwrite  out  1  load PC_new into the program counter at the next edge (combinational)
- PC_new  out  14  next fetch word address (combinational)
- ir_valid  out  1  registered instruction bundle is valid
- ir_word0  out  16  first instruction word
- ir_word1  out  16  second word; 0 for single-word instructions
- ir_two_word  out  1  bundle is a 32-bit instruction
- ir_pc  out  14  address of ir_word0

Function
REQ-003 The state machine SHALL have two states: FETCH (expect first word) and WORD2 (expect second word of a 32-bit instruction).
REQ-004 A word w SHALL be classed as two-word when (w & 16'hFC0F)==16'h9000 (LDS/STS) or (w & 16'hFE0C)==16'h940C (JMP/CALL).
REQ-005 A word SHALL be classed as RJMP when w[15:12]==4'hC, and as JMP when (w & 16'hFE0E)==16'h940C.
REQ-006 Redirect priority SHALL be, highest first: reset, flush, stall, RJMP/JMP resolution, then no redirect.
REQ-007 While reset is high, PC_overwrite SHALL be 0.
REQ-008 When flush=1, the block SHALL drive PC_overwrite=1 and PC_new=ex_target; at the next edge it SHALL go to FETCH, set ir_valid=0, and discard any held word0.
REQ-009 When stall=1 and flush=0, the block SHALL drive PC_overwrite=1 and PC_new=program_counter (re-fetch); all registers and the state SHALL hold.
REQ-010 In FETCH with a single-word, non-RJMP word, the next edge SHALL load: ir_word0=instruction, ir_word1=0, ir_two_word=0, ir_pc=program_counter, ir_valid=1 (latency 1 cycle).
REQ-011 In FETCH with a two-word word, the next edge SHALL store word0 and its pc internally, go to WORD2, and set ir_valid=0.
REQ-012 In WORD2, the next edge SHALL load ir_word0=held word0, ir_word1=instruction, ir_two_word=1, ir_pc=held pc, ir_valid=1, and return to FETCH.
REQ-013 For an RJMP in FETCH, the block SHALL drive PC_overwrite=1 and PC_new=(program_counter+1+sign-extended w[11:0]) modulo 2^14; the RJMP SHALL NOT be emitted, and ir_valid=0 at the next edge.
REQ-014 For a held JMP in WORD2, the block SHALL drive PC_overwrite=1 and PC_new=instruction[13:0] (upper address bits dropped); the JMP SHALL NOT be emitted, ir_valid=0 at the next edge, and the state SHALL return to FETCH.
REQ-015 CALL, LDS and STS SHALL be emitted, not resolved, in this stage.
REQ-016 In all other cases PC_overwrite SHALL be 0; PC_new SHALL then equal program_counter+1 modulo 2^14.
REQ-017 PC arithmetic SHALL wrap modulo 2^14 (14'h3FFF+1 = 0).
REQ-018 ir_valid SHALL be high for exactly one cycle per emitted instruction unless stall holds it.

Reset
REQ-019 At a clock edge with reset=1, the block SHALL set: state=FETCH, ir_valid=0, ir_word0=0, ir_word1=0, ir_two_word=0, ir_pc=0, and held word0/pc=0.
REQ-020 Reset SHALL override flush, stall and a WORD2 in progress; the partial instruction SHALL be discarded.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- NOP (16'h0000) at pc 5 -> next cycle ir_valid=1, ir_word0=0, ir_pc=5, ir_two_word=0; PC_overwrite=0.
- LDS 16'h9000 at pc 10, then 16'h0060 at pc 11 -> one bubble, then ir_valid=1, ir_word0=16'h9000, ir_word1=16'h0060, ir_pc=10, ir_two_word=1.
- RJMP 16'hCFFF at pc 20 -> same cycle PC_overwrite=1, PC_new=20; next cycle ir_valid=0. RJMP 16'hC000 at pc 14'h3FFF -> PC_new=0.
- JMP 16'h940C at pc 3, then 16'h0123 at pc 4 -> in the second cycle PC_overwrite=1, PC_new=14'h0123; no bundle emitted.
- stall=1 for 3 cycles while ir_valid=1 -> outputs held, PC_new=program_counter each cycle; flush=1 with ex_target=7 while in WORD2 -> PC_new=7, then state FETCH, ir_valid=0.
- reset=1 asserted in WORD2 -> all outputs 0 at the next edge; a subsequent single-word instruction is emitted normally.
